// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: resolves load-use,
// branch/jump, data-memory wait (with timeout) and interrupt entry into register enables/flushes.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        ex_memrd,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    input  logic        irq,
    input  logic        irq_en,
    input  logic        stall_clr,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        irq_take,
    output logic        bus_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_IRQ   = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              irq_armed_q, irq_armed_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic lu_s;
    logic irq_ok_s;
    logic pc_we_s, ifid_we_s, idex_we_s, exmem_we_s;
    logic ifid_flush_s, idex_bubble_s, irq_take_s, bus_err_s;

    // Load-use hazard and interrupt acceptance qualifiers.
    always_comb begin
        lu_s = ex_memrd && (ex_rt != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
        irq_ok_s = irq && irq_en && irq_armed_q && !id_jump;
    end

    // Next-state and pipeline-control decode.
    always_comb begin
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        idex_we_s     = 1'b1;
        exmem_we_s    = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        irq_take_s    = 1'b0;
        bus_err_s     = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        // A low irq re-arms; a held irq stays disarmed after being taken once.
        irq_armed_d   = irq ? irq_armed_q : 1'b1;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_we_s    = 1'b0;
                    ifid_we_s  = 1'b0;
                    idex_we_s  = 1'b0;
                    exmem_we_s = 1'b0;
                    state_d    = ST_MWAIT;
                    wait_cnt_d = WAIT_ONE;
                end else if (ex_branch_taken) begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (lu_s) begin
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b0;
                    idex_bubble_s = 1'b1;
                end else if (irq_ok_s) begin
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b0;
                    idex_bubble_s = 1'b1;
                    state_d       = ST_IRQ;
                    irq_armed_d   = 1'b0;
                end else if (id_jump) begin
                    ifid_flush_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MWAIT: begin
                if (!mem_busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = WAIT_ZERO;
                end else if (wait_cnt_q < TIMEOUT_C) begin
                    pc_we_s    = 1'b0;
                    ifid_we_s  = 1'b0;
                    idex_we_s  = 1'b0;
                    exmem_we_s = 1'b0;
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else begin
                    // Give up on the access: let the pipeline advance and flag it.
                    bus_err_s  = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = WAIT_ZERO;
                end
            end
            ST_IRQ: begin
                irq_take_s    = 1'b1;
                ifid_flush_s  = 1'b1;
                idex_bubble_s = 1'b1;
                state_d       = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = WAIT_ZERO;
            end
        endcase
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        if (stall_clr) begin
            stall_cnt_d = 16'h0000;
        end else if (!pc_we_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= WAIT_ZERO;
            irq_armed_q <= 1'b0;
            stall_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            irq_armed_q <= irq_armed_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_we       = pc_we_s;
    assign ifid_we     = ifid_we_s;
    assign idex_we     = idex_we_s;
    assign exmem_we    = exmem_we_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign irq_take    = irq_take_s;
    assign bus_err     = bus_err_s;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand-written corner sequences
// and a randomized run against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int MT = 15;

    // Output bundle order: {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, irq_take, bus_err}
    localparam logic [7:0] O_DEF  = 8'b1111_0000;
    localparam logic [7:0] O_FRZ  = 8'b0000_0000;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_LU   = 8'b0011_0100;
    localparam logic [7:0] O_JMP  = 8'b1111_1000;
    localparam logic [7:0] O_IRQ  = 8'b1111_1110;
    localparam logic [7:0] O_BERR = 8'b1111_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, id_jump, ex_memrd, ex_branch_taken;
    logic        mem_busy, irq, irq_en, stall_clr;
    logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, irq_take, bus_err;
    logic [15:0] stall_cnt;
    logic [7:0]  outs;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(MT), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .irq(irq), .irq_en(irq_en), .stall_clr(stall_clr),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .irq_take(irq_take),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, irq_take, bus_err};

    typedef struct {
        logic [4:0] rs, rt, xrt;
        logic       urs, urt, jmp, memrd, br, busy, rq, en;
        logic [7:0] exp;
        int         inc;
        logic [7:0] exp_next;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic jmp, input logic memrd,
                                input logic [4:0] xrt, input logic br, input logic busy,
                                input logic rq, input logic en, input logic [7:0] exp,
                                input int inc, input logic [7:0] exp_next);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.jmp = jmp; v.memrd = memrd;
        v.xrt = xrt; v.br = br; v.busy = busy; v.rq = rq; v.en = en;
        v.exp = exp; v.inc = inc; v.exp_next = exp_next;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_memrd = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        irq = 1'b0; irq_en = 1'b0; stall_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic hazard();
        return ex_memrd && (ex_rt != 5'd0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    endfunction

    // Behavioural model state
    int   m_wait;
    bit   m_take, m_armed, m_accept;
    int   m_stall;
    logic [7:0] m_exp;

    task automatic model_outputs();
        m_accept = 1'b0;
        if (m_take)                     m_exp = O_IRQ;
        else if (m_wait > 0)            m_exp = !mem_busy ? O_DEF : (m_wait < MT ? O_FRZ : O_BERR);
        else if (mem_busy)              m_exp = O_FRZ;
        else if (ex_branch_taken)       m_exp = O_BR;
        else if (hazard())              m_exp = O_LU;
        else if (irq && irq_en && m_armed && !id_jump) begin
            m_exp = O_LU;
            m_accept = 1'b1;
        end
        else if (id_jump)               m_exp = O_JMP;
        else                            m_exp = O_DEF;
    endtask

    task automatic model_update();
        if (m_take)          m_wait = 0;
        else if (m_wait > 0) m_wait = (mem_busy && m_wait < MT) ? m_wait + 1 : 0;
        else                 m_wait = mem_busy ? 1 : 0;
        m_take = m_accept;
        if (!irq)          m_armed = 1'b1;
        else if (m_accept) m_armed = 1'b0;
        if (stall_clr)                           m_stall = 0;
        else if (!m_exp[7] && m_stall < 65535)   m_stall = m_stall + 1;
    endtask

    initial begin
        int s0;
        int burst;
        reset = 1'b1;
        set_idle();

        // Reset state, even with an interrupt pending
        irq = 1'b1; irq_en = 1'b1;
        @(negedge clk);
        check("reset_outs", {24'd0, outs}, {24'd0, O_DEF});
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        do_reset();

        vecs[0]  = mk(5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0, 0, 0, O_LU,  1, O_DEF);
        vecs[1]  = mk(5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 0, 0, O_DEF, 0, O_DEF);
        vecs[2]  = mk(5'd1, 5'd7, 1, 1, 0, 1, 5'd7, 0, 0, 0, 0, O_LU,  1, O_DEF);
        vecs[3]  = mk(5'd1, 5'd7, 1, 0, 0, 1, 5'd7, 0, 0, 0, 0, O_DEF, 0, O_DEF);
        vecs[4]  = mk(5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 0, 0, 0, 0, O_DEF, 0, O_DEF);
        vecs[5]  = mk(5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 1, 0, 0, 0, O_BR,  0, O_DEF);
        vecs[6]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0, O_FRZ, 1, O_DEF);
        vecs[7]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 1, O_LU,  1, O_IRQ);
        vecs[8]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 0, O_DEF, 0, O_DEF);
        vecs[9]  = mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, 1, O_JMP, 0, O_DEF);
        vecs[10] = mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 0, O_JMP, 0, O_DEF);
        vecs[11] = mk(5'd3, 5'd0, 1, 0, 0, 1, 5'd3, 0, 0, 1, 1, O_LU,  1, O_DEF);

        foreach (vecs[i]) begin
            set_idle();
            step();
            step();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rs = vecs[i].urs;
            id_uses_rt = vecs[i].urt; id_jump = vecs[i].jmp; ex_memrd = vecs[i].memrd;
            ex_rt = vecs[i].xrt; ex_branch_taken = vecs[i].br; mem_busy = vecs[i].busy;
            irq = vecs[i].rq; irq_en = vecs[i].en;
            s0 = int'(stall_cnt);
            @(negedge clk);
            check($sformatf("vec%0d_outs", i), {24'd0, outs}, {24'd0, vecs[i].exp});
            step();
            check($sformatf("vec%0d_cnt", i), {16'd0, stall_cnt}, 32'(s0 + vecs[i].inc));
            set_idle();
            @(negedge clk);
            check($sformatf("vec%0d_next", i), {24'd0, outs}, {24'd0, vecs[i].exp_next});
            step();
        end

        // Short memory wait: three frozen cycles, no bus error
        set_idle(); step();
        s0 = int'(stall_cnt);
        mem_busy = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("mem3_c%0d", c), {24'd0, outs}, {24'd0, O_FRZ});
            step();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        check("mem3_release", {24'd0, outs}, {24'd0, O_DEF});
        check("mem3_cnt", {16'd0, stall_cnt}, 32'(s0 + 3));
        step();

        // Long memory wait: timeout pulse on cycle 16, re-entry from 17
        set_idle(); step();
        mem_busy = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check($sformatf("mem20_c%0d", c), {24'd0, outs}, {24'd0, (c == 16) ? O_BERR : O_FRZ});
            step();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        check("mem20_release", {24'd0, outs}, {24'd0, O_DEF});
        step();

        // Held interrupt taken once, then again after a low cycle
        set_idle(); step(); step();
        irq = 1'b1; irq_en = 1'b1;
        @(negedge clk); check("irq_accept", {24'd0, outs}, {24'd0, O_LU}); step();
        @(negedge clk); check("irq_take", {24'd0, outs}, {24'd0, O_IRQ}); step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); check("irq_held_once", {24'd0, outs}, {24'd0, O_DEF}); step();
        end
        irq = 1'b0;
        @(negedge clk); check("irq_low", {24'd0, outs}, {24'd0, O_DEF}); step();
        irq = 1'b1;
        @(negedge clk); check("irq_rearm_accept", {24'd0, outs}, {24'd0, O_LU}); step();
        @(negedge clk); check("irq_rearm_take", {24'd0, outs}, {24'd0, O_IRQ}); step();

        // Interrupt deferred by a jump in ID
        set_idle(); step();
        irq = 1'b1; irq_en = 1'b1; id_jump = 1'b1;
        @(negedge clk); check("irq_defer_jump", {24'd0, outs}, {24'd0, O_JMP}); step();
        id_jump = 1'b0;
        @(negedge clk); check("irq_defer_accept", {24'd0, outs}, {24'd0, O_LU}); step();
        @(negedge clk); check("irq_defer_take", {24'd0, outs}, {24'd0, O_IRQ}); step();

        // Reset during memory wait with stall_cnt = 7
        do_reset();
        mem_busy = 1'b1;
        repeat (7) step();
        @(negedge clk);
        check("mwait_pre_cnt", {16'd0, stall_cnt}, 32'd7);
        reset = 1'b1; mem_busy = 1'b0; ex_branch_taken = 1'b1;
        #1;
        check("mwait_reset_outs", {24'd0, outs}, {24'd0, O_BR});
        check("mwait_reset_cnt", {16'd0, stall_cnt}, 32'd0);
        step();
        reset = 1'b0;
        set_idle();

        // Reset while in the interrupt-entry cycle suppresses irq_take
        step(); step();
        irq = 1'b1; irq_en = 1'b1;
        step();
        reset = 1'b1;
        #1;
        check("irq_reset_outs", {24'd0, outs}, {24'd0, O_DEF});
        step();
        reset = 1'b0;
        set_idle();

        // Randomized run against the behavioural model
        do_reset();
        m_wait = 0; m_take = 1'b0; m_armed = 1'b0; m_stall = 0; burst = 0;
        for (int c = 0; c < 3000; c++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
            ex_memrd = 1'($urandom_range(0, 1));
            id_jump = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            irq_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) irq = ~irq;
            stall_clr = ($urandom_range(0, 63) == 0);
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = int'($urandom_range(1, 20));
            mem_busy = (burst > 0);
            if (burst > 0) burst--;
            model_outputs();
            @(negedge clk);
            check("rand_outs", {24'd0, outs}, {24'd0, m_exp});
            check("rand_cnt", {16'd0, stall_cnt}, 32'(m_stall));
            @(posedge clk);
            model_update();
            #1;
        end

        // Saturation of stall_cnt under a continuous load-use stall, then clear
        do_reset();
        ex_memrd = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        check("sat_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
        step();
        check("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check("sat_still_stall", {31'd0, pc_we}, 32'd0);
        stall_clr = 1'b1;
        step();
        check("clr_wins", {16'd0, stall_cnt}, 32'd0);
        stall_clr = 1'b0;
        step();
        check("after_clr_inc", {16'd0, stall_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage MIPS pipeline. Each cycle it decides whether PC, IF/ID, ID/EX and EX/MEM advance, hold or are flushed. The decision covers four cases: load-use hazards, taken branches and jumps, data-memory wait states with timeout, and interrupt entry. It drives the enable and flush inputs of the pipeline registers. A bubble zeroes RegWr, MemWr and MemRd entering ID/EX. It also keeps a saturating stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive freeze cycles for one memory wait; valid range 1 to 2^WAIT_W-1.
- WAIT_W, 4: width of the wait counter.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- id_jump  in  1  J/JAL/JR/JALR decoded in ID.
- ex_memrd  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of that load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_busy  in  1  data memory access in MEM not yet complete.
- irq  in  1  level interrupt request.
- irq_en  in  1  interrupts globally enabled.
- stall_clr  in  1  synchronous clear of stall_cnt.
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  register write enables.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load zeroed control into ID/EX.
- irq_take  out  1  PC mux selects exception vector; EPC capture strobe.
- bus_err  out  1  one-cycle memory-timeout pulse.
- stall_cnt  out  16  cycles with pc_we=0, saturating.

## Operation
- State: FSM {RUN, MWAIT, IRQ}, wait_cnt[WAIT_W-1:0], irq_armed, stall_cnt.
- Outputs are combinational from the current state and inputs.
- Default: all four _we = 1; flush, bubble, irq_take and bus_err = 0.
- Load-use hazard (lu) is defined as: ex_memrd && ex_rt != 0 && ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt)).
- RUN applies the first matching rule in this priority order:
  1. mem_busy: freeze (all _we = 0, no flush or bubble); next state MWAIT, wait_cnt <= 1.
  2. ex_branch_taken: pc_we = 1, ifid_flush = 1, idex_bubble = 1.
  3. lu: pc_we = 0, ifid_we = 0, idex_bubble = 1.
  4. irq && irq_en && irq_armed && !id_jump: pc_we = 0, ifid_we = 0, idex_bubble = 1; next state IRQ, irq_armed <= 0.
  5. id_jump: ifid_flush = 1.
- MWAIT:
  - If !mem_busy: default outputs; next state RUN, wait_cnt <= 0.
  - Else if wait_cnt < MEM_TIMEOUT: freeze; wait_cnt++.
  - Else: bus_err = 1 and default enables (pipeline advances); next state RUN, wait_cnt <= 0.
- IRQ lasts exactly one cycle: irq_take = 1, pc_we = 1, ifid_flush = 1, idex_bubble = 1; next state RUN. mem_busy is not sampled in IRQ.
- irq_armed <= 1 on any cycle with irq = 0. A held irq is therefore taken only once.
- stall_cnt:
  - stall_clr = 1: clears to 0, and clear wins over increment.
  - Otherwise increments when pc_we = 0, holding at 16'hFFFF.

## Timing
- Reset (asynchronous): state RUN, wait_cnt 0, irq_armed 0, stall_cnt 0.
- While reset is asserted: outputs take RUN values from the current inputs, and irq_take = bus_err = 0.
- Stall and flush decisions have zero-cycle latency: they take effect at the next clock edge.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX on that edge.
- A taken branch flushes the 2 wrong-path instructions. A jump kills the 1 instruction in IF.
- Vector fetch: irq accepted in cycle N gives irq_take in N+1, and the vector is fetched in N+2.
- Memory wait: a single wait freezes at most MEM_TIMEOUT cycles. The next cycle either advances or, if mem_busy is still high, pulses bus_err.
- If mem_busy persists after bus_err, RUN re-enters MWAIT on the following cycle.
- Reset in mid-MWAIT or mid-IRQ aborts the operation immediately, with no irq_take or bus_err pulse.

## Test plan
- Load-use: ex_memrd = 1, ex_rt = 5, id_rs = 5, id_uses_rs = 1 -> pc_we = ifid_we = 0 and idex_bubble = 1 for one cycle, stall_cnt +1. Same with ex_rt = 0 -> no stall.
- Branch plus load-use in the same cycle -> pc_we = 1, ifid_flush = 1, idex_bubble = 1, stall_cnt unchanged.
- mem_busy high for 3 cycles -> all _we = 0 for exactly 3 cycles, stall_cnt +3, bus_err never asserted.
- mem_busy held for 20 cycles, MEM_TIMEOUT = 15 -> freeze cycles 1–15, bus_err = 1 with enables = 1 in cycle 16, freeze again from cycle 17.
- irq held high with irq_en = 1:
  - Expect exactly one irq_take pulse, one cycle after acceptance.
  - irq arriving with id_jump = 1 is deferred one cycle.
  - After irq goes low then high again, expect a second pulse.
- Reset asserted during MWAIT with stall_cnt = 7 -> state RUN, stall_cnt = 0 and enables = 1 immediately. stall_cnt stays at 16'hFFFF under continued stalls.
